// File: rtl/mul_pkg.sv
// mul_pkg: shared types and constants for the sequential Booth multiplier.
package mul_pkg;
    localparam int W = 8;
    localparam int STEPS = 8;
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_e;
endpackage

// File: rtl/sub_8bit.sv
// sub_8bit: combinational 8-bit add (op=0) / subtract (op=1) with carry-in and signed overflow.
module sub_8bit (
    input  logic       op,
    input  logic       ci,
    input  logic [7:0] x,
    input  logic [7:0] y,
    output logic [7:0] r,
    output logic       of
);
    logic [7:0] yy;
    always_comb begin
        yy = op ? ~y : y;
        r  = x + yy + {7'd0, op ^ ci};
        of = (x[7] == yy[7]) && (r[7] != x[7]);
    end
endmodule

// File: rtl/mul_8bit_seq.sv
// mul_8bit_seq: signed 8x8->16 radix-2 Booth multiplier, one add/sub per clock via sub_8bit.
module mul_8bit_seq
    import mul_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    x,
    input  logic [W-1:0]    y,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*W-1:0]  p,
    output logic            busy
);
    state_e         state_q, state_d;
    logic [W-1:0]   a_q, a_d, q_q, q_d, m_q, m_d, r, a_new;
    logic           q1_q, q1_d, of, do_op, msb;
    logic [2:0]     cnt_q, cnt_d;
    logic [2*W-1:0] p_q, p_d;
    logic           in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;
    logic [1:0]     booth;

    sub_8bit u_sub (
        .op(booth == BOOTH_SUB),
        .ci(1'b0),
        .x (a_q),
        .y (m_q),
        .r (r),
        .of(of)
    );

    always_comb begin
        booth = {q_q[0], q1_q};
        do_op = (booth == BOOTH_ADD) || (booth == BOOTH_SUB);
        a_new = do_op ? r : a_q;
        // overflow flips r[7] back to the true sign of the 9-bit sum
        msb = do_op ? (r[7] ^ of) : a_q[7];
        state_d = state_q;
        a_d = a_q;
        q_d = q_q;
        q1_d = q1_q;
        m_d = m_q;
        cnt_d = cnt_q;
        p_d = p_q;
        in_ready_d = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d = busy_q;
        case (state_q)
            IDLE: if (in_valid && in_ready_q) begin
                {a_d, q_d, q1_d, m_d, cnt_d} = {{W{1'b0}}, y, 1'b0, x, 3'd0};
                state_d = RUN;
                in_ready_d = 1'b0;
                busy_d = 1'b1;
            end
            RUN: begin
                {a_d, q_d, q1_d} = {msb, a_new, q_q};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'(STEPS - 1)) begin
                    p_d = {msb, a_new, q_q[W-1:1]};
                    state_d = DONE;
                    busy_d = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            DONE: if (out_ready) begin
                state_d = IDLE;
                out_valid_d = 1'b0;
                in_ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                in_ready_d = 1'b1;
                out_valid_d = 1'b0;
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q <= '0;
            q_q <= '0;
            q1_q <= 1'b0;
            m_q <= '0;
            cnt_q <= '0;
            p_q <= '0;
            in_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            q_q <= q_d;
            q1_q <= q1_d;
            m_q <= m_d;
            cnt_q <= cnt_d;
            p_q <= p_d;
            in_ready_q <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q <= busy_d;
        end
    end

    assign in_ready = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy = busy_q;
    assign p = p_q;
endmodule

// File: tb/tb_mul_8bit_seq.sv
// tb_mul_8bit_seq: directed and random checks of the Booth multiplier's product, latency and handshakes.
module tb_mul_8bit_seq;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready, in_ready, out_valid, busy;
    logic [7:0]  x, y;
    logic [15:0] p;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    mul_8bit_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // keep=1 leaves in_valid high with a 2*2 request pending while this operation runs
    task automatic do_mul(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                          input int hold, input bit keep, input string tag);
        int n, nb;
        bit blocked;
        @(negedge clk);
        chk({tag, "_idle_ov"}, {15'd0, out_valid}, 16'd0);
        chk({tag, "_rdy"}, {15'd0, in_ready}, 16'd1);
        x = a; y = b; in_valid = 1'b1;
        @(posedge clk); #1;
        if (keep) begin x = 8'd2; y = 8'd2; end else in_valid = 1'b0;
        n = 0; nb = 0; blocked = 1'b1;
        while (!out_valid && n < 20) begin
            nb += int'(busy);
            blocked &= !in_ready;
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, 16'(n), 16'd8);
        chk({tag, "_busy"}, 16'(nb), 16'd8);
        chk({tag, "_p"}, p, exp);
        for (int i = 0; i < hold; i++) begin
            blocked &= !in_ready;
            @(posedge clk); #1;
            chk({tag, "_hold_ov"}, {15'd0, out_valid}, 16'd1);
            chk({tag, "_hold_p"}, p, exp);
        end
        if (keep) chk({tag, "_blocked"}, {15'd0, blocked}, 16'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_ov_drop"}, {15'd0, out_valid}, 16'd0);
        chk({tag, "_rdy_back"}, {15'd0, in_ready}, 16'd1);
        chk({tag, "_p_keep"}, p, exp);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic signed [15:0] re;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
        #12;
        chk("rst_rdy", {15'd0, in_ready}, 16'd1);
        chk("rst_ov", {15'd0, out_valid}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_p", p, 16'd0);
        @(negedge clk); rst_n = 1'b1;

        do_mul(8'd3, 8'd5, 16'd15, 0, 1'b0, "m3x5");
        do_mul(8'hF9, 8'd5, 16'hFFDD, 0, 1'b0, "mn7x5");
        do_mul(8'h80, 8'h80, 16'h4000, 0, 1'b0, "mn128xn128");
        do_mul(8'h80, 8'h7F, 16'hC080, 0, 1'b0, "mn128x127");
        do_mul(8'd0, 8'hFF, 16'd0, 0, 1'b0, "m0xn1");
        do_mul(8'd127, 8'd0, 16'd0, 0, 1'b0, "m127x0");
        do_mul(8'd12, 8'hF5, 16'hFF7C, 5, 1'b1, "m12xn11");
        do_mul(8'd2, 8'd2, 16'd4, 0, 1'b0, "m2x2");

        @(negedge clk);
        x = 8'd100; y = 8'd100; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ov", {15'd0, out_valid}, 16'd0);
        chk("arst_p", p, 16'd0);
        chk("arst_rdy", {15'd0, in_ready}, 16'd1);
        chk("arst_busy", {15'd0, busy}, 16'd0);
        @(negedge clk); rst_n = 1'b1;
        do_mul(8'hFF, 8'hFF, 16'd1, 0, 1'b0, "mn1xn1");

        for (int i = 0; i < 2000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            re = $signed(ra) * $signed(rb);
            do_mul(ra, rb, re, 0, 1'b0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
